// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace unit: record layout, FSM states and the
// word-select helper used by the serializer.
package cpu_trace_pkg;

  localparam int TRACE_WORDS = 4;
  localparam int WORD_W      = 32;
  localparam int IDX_W       = $clog2(TRACE_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] cycle;
    logic [WORD_W-1:0] stall;
    logic [WORD_W-1:0] flush;
    logic [WORD_W-1:0] pc;
  } trace_rec_t;

  // Word order on the stream: cycle, stall, flush, pc.
  function automatic logic [WORD_W-1:0] rec_word(input trace_rec_t rec,
                                                 input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] w;
    unique case (idx)
      2'd0:    w = rec.cycle;
      2'd1:    w = rec.stall;
      2'd2:    w = rec.flush;
      default: w = rec.pc;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cpu_trace_unit_if.sv
// Valid/ready trace word stream; the trace unit drives it as master.
interface cpu_trace_unit_if;
  import cpu_trace_pkg::*;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [WORD_W-1:0] out_data_o;
  logic              out_last_o;

  modport master (
    output out_valid_o,
    output out_data_o,
    output out_last_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o,
    input  out_data_o,
    input  out_last_o,
    output out_ready_i
  );

endinterface

// File: rtl/cpu_trace_unit_fifo.sv
// Synchronous record FIFO. A push into a full FIFO is still taken when a pop
// happens on the same edge, because the slot being freed is the one written.
module trace_rec_fifo
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  trace_rec_t push_rec_i,
  input  logic       pop_i,
  output trace_rec_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_rec_i;
  end

  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/cpu_trace_unit.sv
// Per-cycle CPU trace producer: capture FSM, event counters and a 4-word
// serializer draining a small record FIFO.
module cpu_trace_unit
  import cpu_trace_pkg::*;
#(
  parameter int MAX_CYCLES = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     hd_stall_i,
  input  logic                     jump_i,
  input  logic                     branch_i,
  input  logic                     flush_i,
  input  logic [WORD_W-1:0]        pc_i,
  cpu_trace_unit_if.master         trace_if,
  output logic                     done_o,
  output logic                     overflow_o
);

  localparam logic [WORD_W-1:0] LAST_CYCLE = WORD_W'(MAX_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(TRACE_WORDS - 1);

  trace_state_e      state_q, state_d;
  logic [WORD_W-1:0] cycle_q, cycle_d;
  logic [WORD_W-1:0] stall_q, stall_d;
  logic [WORD_W-1:0] flush_q, flush_d;
  logic              overflow_q, overflow_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic       capture;
  logic       stall_inc;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fire;
  logic       last_word;
  logic       pop;
  trace_rec_t cap_rec;
  trace_rec_t head_rec;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (start_i && (cycle_q == LAST_CYCLE)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      RUN:     capture = start_i;
      DONE:    done_o  = 1'b1;
      default: ;
    endcase
  end

  // A stall that coincides with a jump/branch decode is resolved by the
  // flush instead, so it is not counted as a load-use stall.
  assign stall_inc = hd_stall_i & ~jump_i & ~branch_i;

  always_comb begin
    cycle_d    = cycle_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    overflow_d = overflow_q;
    if (capture) begin
      cycle_d = cycle_q + 1'b1;
      stall_d = stall_q + WORD_W'(stall_inc);
      flush_d = flush_q + WORD_W'(flush_i);
      if (fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q    <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;

  // Snapshot holds the pre-update counter values.
  assign cap_rec = '{cycle: cycle_q, stall: stall_q, flush: flush_q, pc: pc_i};

  trace_rec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (capture),
    .push_rec_i (cap_rec),
    .pop_i      (pop),
    .head_o     (head_rec),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign fire      = trace_if.out_valid_o & trace_if.out_ready_i;
  assign last_word = (idx_q == LAST_IDX);
  assign pop       = fire & last_word;

  always_comb begin
    idx_d = idx_q;
    if (fire) idx_d = last_word ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  // Head and idx only move on a handshake, so data/last hold while stalled.
  assign trace_if.out_valid_o = ~fifo_empty;
  assign trace_if.out_data_o  = fifo_empty ? '0 : rec_word(head_rec, idx_q);
  assign trace_if.out_last_o  = ~fifo_empty & last_word;

endmodule

// File: tb/tb_cpu_trace_unit.sv
// Directed bench for cpu_trace_unit: capture, overflow, counter rules,
// full run to DONE, stalled streaming and mid-record reset.
module tb_cpu_trace_unit;
  import cpu_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        hd_stall = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = '0;
  logic        done;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_trace_unit_if tif ();

  cpu_trace_unit #(
    .MAX_CYCLES (30),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .hd_stall_i (hd_stall),
    .jump_i     (jump),
    .branch_i   (branch),
    .flush_i    (flush),
    .pc_i       (pc),
    .trace_if   (tif),
    .done_o     (done),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tif.out_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic go_run(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_norecord"}, 32'(tif.out_valid_o), 32'd0);
  endtask

  task automatic cap(input logic [31:0] p, input logic h, input logic j,
                     input logic b, input logic f);
    pc = p; hd_stall = h; jump = j; branch = b; flush = f;
    start = 1'b1;
    tick();
    start = 1'b0; hd_stall = 1'b0; jump = 1'b0; branch = 1'b0; flush = 1'b0;
  endtask

  task automatic expect_record(input string tag, input logic [31:0] c, input logic [31:0] s,
                               input logic [31:0] f, input logic [31:0] p);
    logic [31:0] w [4];
    int wait_cyc;
    w[0] = c; w[1] = s; w[2] = f; w[3] = p;
    tif.out_ready_i = 1'b1;
    wait_cyc = 0;
    while (tif.out_valid_o !== 1'b1 && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    check({tag, "_valid"}, 32'(tif.out_valid_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_w%0d", tag, k), tif.out_data_o, w[k]);
      check($sformatf("%s_last%0d", tag, k), 32'(tif.out_last_o), 32'(k == 3));
      tick();
    end
    tif.out_ready_i = 1'b0;
    $display("record %s: cycle=%0d stall=%0d flush=%0d pc=0x%08h", tag, c, s, f, p);
  endtask

  logic [31:0] exp5 [12];

  initial begin
    int k;
    logic r;
    tif.out_ready_i = 1'b0;

    // 1: reset state, fill FIFO with ready low, overflow on 5th capture
    do_reset();
    check("rst_valid", 32'(tif.out_valid_o), 32'd0);
    check("rst_data", tif.out_data_o, 32'd0);
    check("rst_last", 32'(tif.out_last_o), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    go_run("t1");
    cap(32'h00, 0, 0, 0, 0);
    cap(32'h04, 0, 0, 0, 0);
    cap(32'h08, 0, 0, 0, 0);
    cap(32'h0C, 0, 0, 0, 0);
    check("t1_full_valid", 32'(tif.out_valid_o), 32'd1);
    check("t1_full_head", tif.out_data_o, 32'd0);
    check("t1_full_ovf", 32'(overflow), 32'd0);
    cap(32'h10, 0, 0, 0, 0);
    check("t1_ovf_set", 32'(overflow), 32'd1);
    expect_record("t1_r0", 0, 0, 0, 32'h00);
    expect_record("t1_r1", 1, 0, 0, 32'h04);
    expect_record("t1_r2", 2, 0, 0, 32'h08);
    expect_record("t1_r3", 3, 0, 0, 32'h0C);
    check("t1_empty", 32'(tif.out_valid_o), 32'd0);
    cap(32'h14, 0, 0, 0, 0);
    expect_record("t1_after_drop", 5, 0, 0, 32'h14);
    check("t1_ovf_sticky", 32'(overflow), 32'd1);

    // 2: single capture streamed with ready high
    do_reset();
    go_run("t2");
    tif.out_ready_i = 1'b1;
    cap(32'h10, 0, 0, 0, 0);
    expect_record("t2_rec", 0, 0, 0, 32'h10);
    check("t2_idle_after", 32'(tif.out_valid_o), 32'd0);

    // 3: stall counted only without jump/branch; flush counted
    cap(32'h14, 1, 0, 0, 0);
    expect_record("t3_a", 1, 0, 0, 32'h14);
    cap(32'h18, 1, 0, 0, 0);
    expect_record("t3_b", 2, 1, 0, 32'h18);
    cap(32'h1C, 1, 1, 0, 0);
    expect_record("t3_c", 3, 2, 0, 32'h1C);
    cap(32'h20, 1, 0, 1, 0);
    expect_record("t3_d", 4, 2, 0, 32'h20);
    cap(32'h24, 0, 0, 0, 1);
    expect_record("t3_e", 5, 2, 0, 32'h24);
    cap(32'h28, 0, 0, 0, 0);
    expect_record("t3_f", 6, 2, 1, 32'h28);
    check("t3_ovf", 32'(overflow), 32'd0);

    // 4: full run to DONE, one capture every 4 cycles
    do_reset();
    go_run("t4");
    tif.out_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      pc = 32'(i * 4);
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("t4_done%0d", i), 32'(done), 32'(i == 29));
      check($sformatf("t4_valid%0d", i), 32'(tif.out_valid_o), 32'd1);
      check($sformatf("t4_cycle%0d", i), tif.out_data_o, 32'(i));
      check($sformatf("t4_last0_%0d", i), 32'(tif.out_last_o), 32'd0);
      tick();
      check($sformatf("t4_stall%0d", i), tif.out_data_o, 32'd0);
      tick();
      check($sformatf("t4_flush%0d", i), tif.out_data_o, 32'd0);
      tick();
      check($sformatf("t4_pc%0d", i), tif.out_data_o, 32'(i * 4));
      check($sformatf("t4_last3_%0d", i), 32'(tif.out_last_o), 32'd1);
      $display("record t4_%0d: cycle=%0d pc=0x%08h", i, i, i * 4);
    end
    tick();
    check("t4_drained", 32'(tif.out_valid_o), 32'd0);
    start = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    start = 1'b0;
    check("t4_no_capture_done", 32'(tif.out_valid_o), 32'd0);
    check("t4_done_hold", 32'(done), 32'd1);
    check("t4_ovf", 32'(overflow), 32'd0);

    // 5: random backpressure across three buffered records
    do_reset();
    go_run("t5");
    cap(32'hA0, 1, 0, 0, 1);
    cap(32'hB0, 0, 0, 0, 0);
    cap(32'hC0, 1, 0, 0, 0);
    exp5[0] = 0; exp5[1]  = 0; exp5[2]  = 0; exp5[3]  = 32'hA0;
    exp5[4] = 1; exp5[5]  = 1; exp5[6]  = 1; exp5[7]  = 32'hB0;
    exp5[8] = 2; exp5[9]  = 1; exp5[10] = 1; exp5[11] = 32'hC0;
    k = 0;
    for (int cyc = 0; cyc < 200 && k < 12; cyc++) begin
      check($sformatf("t5_valid%0d", k), 32'(tif.out_valid_o), 32'd1);
      check($sformatf("t5_data%0d", k), tif.out_data_o, exp5[k]);
      check($sformatf("t5_last%0d", k), 32'(tif.out_last_o), 32'((k % 4) == 3));
      r = 1'($urandom_range(0, 1));
      tif.out_ready_i = r;
      tick();
      if (r) k++;
    end
    tif.out_ready_i = 1'b0;
    check("t5_words", 32'(k), 32'd12);
    check("t5_empty", 32'(tif.out_valid_o), 32'd0);
    $display("record t5: 12 words streamed under backpressure");

    // 6: reset while word1 is on the output, then restart
    do_reset();
    go_run("t6");
    cap(32'h40, 1, 0, 0, 0);
    cap(32'h44, 0, 0, 0, 0);
    expect_record("t6_r0", 0, 0, 0, 32'h40);
    tif.out_ready_i = 1'b1;
    check("t6_w0", tif.out_data_o, 32'd1);
    tick();
    check("t6_w1", tif.out_data_o, 32'd1);
    check("t6_w1_last", 32'(tif.out_last_o), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", 32'(tif.out_valid_o), 32'd0);
    check("t6_rst_data", tif.out_data_o, 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    go_run("t6b");
    cap(32'h50, 0, 0, 0, 0);
    expect_record("t6_restart", 0, 0, 0, 32'h50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
